// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared widths, opcode constants, FSM state encodings and a
//                small helper for the alu_unit block.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MULT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Shift amount is the low nibble of the right operand; upper bits ignored.
    function automatic logic [3:0] shift_amount(input logic [DATA_W-1:0] r);
        return r[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : 16x16 unsigned shift-add multiplier, one partial product per
//                step, 16 steps counted by a 4-bit counter. o_done stays high
//                after the last step until the next load.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [PROD_W-1:0] o_product,
    output logic              o_done
);

    logic [PROD_W-1:0] acc_q,    acc_d;
    logic [PROD_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              done_q,   done_d;

    // Load operands, or accumulate one partial product per step.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        if (i_load) begin
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, i_a};
            mplier_d = i_b;
            cnt_d    = '0;
            done_d   = 1'b0;
        end else if (i_step && !done_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                done_d = 1'b1;
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign o_product = acc_q;
    assign o_done    = done_q;

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_unit
//  Description : 16-bit ALU with registered result and flags. Single-cycle
//                ops complete one edge after START; MUL uses the sequential
//                multiplier and completes 17 edges after START.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_unit
    import alu_pkg::*;
(
    input  logic              ck,
    input  logic              res,
    input  logic              START,
    input  logic [2:0]        OP,
    input  logic [DATA_W-1:0] L,
    input  logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] O,
    output logic              DONE,
    output logic              BUSY,
    output logic              ZF,
    output logic              NF,
    output logic              CF
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] l_q, l_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] o_q, o_d;
    logic              zf_q, zf_d;
    logic              nf_q, nf_d;
    logic              cf_q, cf_d;
    logic              done_q, done_d;

    logic              w_mul_load;
    logic              w_mul_step;
    logic              w_mul_done;
    logic [PROD_W-1:0] w_product;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [3:0]        w_amt;
    logic [DATA_W:0]   w_shl_ext;
    logic [DATA_W:0]   w_shr_ext;
    logic [DATA_W-1:0] w_res;
    logic              w_cf;

    alu_mul_seq u_mul (
        .clk       (ck),
        .rst_n     (res),
        .i_load    (w_mul_load),
        .i_step    (w_mul_step),
        .i_a       (L),
        .i_b       (R),
        .o_product (w_product),
        .o_done    (w_mul_done)
    );

    // Single-cycle datapath on the captured operands. The extra bit in the
    // shift vectors catches the last bit shifted out (0 for a zero shift).
    always_comb begin
        w_sum     = {1'b0, l_q} + {1'b0, r_q};
        w_diff    = l_q - r_q;
        w_amt     = shift_amount(r_q);
        w_shl_ext = {1'b0, l_q} << w_amt;
        w_shr_ext = {l_q, 1'b0} >> w_amt;
        w_res     = '0;
        w_cf      = 1'b0;
        case (op_q)
            OP_ADD: begin
                w_res = w_sum[DATA_W-1:0];
                w_cf  = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_res = w_diff;
                w_cf  = (l_q < r_q);
            end
            OP_AND: w_res = l_q & r_q;
            OP_OR:  w_res = l_q | r_q;
            OP_XOR: w_res = l_q ^ r_q;
            OP_SHL: begin
                w_res = w_shl_ext[DATA_W-1:0];
                w_cf  = w_shl_ext[DATA_W];
            end
            OP_SHR: begin
                w_res = w_shr_ext[DATA_W:1];
                w_cf  = w_shr_ext[0];
            end
            default: begin
                w_res = '0;
                w_cf  = 1'b0;
            end
        endcase
    end

    // Next-state, operand capture and result/flag update.
    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        r_d        = r_q;
        op_d       = op_q;
        o_d        = o_q;
        zf_d       = zf_q;
        nf_d       = nf_q;
        cf_d       = cf_q;
        done_d     = 1'b0;
        w_mul_load = 1'b0;
        w_mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    l_d  = L;
                    r_d  = R;
                    op_d = OP;
                    if (OP == OP_MUL) begin
                        w_mul_load = 1'b1;
                        state_d    = ST_MULT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                o_d     = w_res;
                zf_d    = (w_res == '0);
                nf_d    = w_res[DATA_W-1];
                cf_d    = w_cf;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_MULT: begin
                if (w_mul_done) begin
                    o_d     = w_product[DATA_W-1:0];
                    zf_d    = (w_product[DATA_W-1:0] == '0);
                    nf_d    = w_product[DATA_W-1];
                    cf_d    = (w_product[PROD_W-1:DATA_W] != '0);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    w_mul_step = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset abandons any operation in flight.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            op_q    <= '0;
            o_q     <= '0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            cf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            op_q    <= op_d;
            o_q     <= o_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            cf_q    <= cf_d;
            done_q  <= done_d;
        end
    end

    assign O    = o_q;
    assign ZF   = zf_q;
    assign NF   = nf_q;
    assign CF   = cf_q;
    assign DONE = done_q;
    assign BUSY = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have port: ck  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: res  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port: START  input  1  request to begin an operation on current L, R, OP.
REQ-004 SHALL have port: OP  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL.
REQ-005 SHALL have port: L  input  16  left operand, fed from the register file L output.
REQ-006 SHALL have port: R  input  16  right operand, fed from the register file R output.
REQ-007 SHALL have port: O  output  16  registered result, fed to the register file O input.
REQ-008 SHALL have port: DONE  output  1  one-cycle pulse marking O valid; intended to drive register file OIN.
REQ-009 SHALL have port: BUSY  output  1  high whenever state is not IDLE.
REQ-010 SHALL have ports: ZF, NF, CF  output  1 each  zero, negative and carry flags.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, MULT, DONE; BUSY = (state != IDLE).
REQ-012 In IDLE with START=1 at edge k: SHALL capture L, R and OP; go to MULT if OP=7, otherwise EXEC.
REQ-013 EXEC: at edge k+1, SHALL write O and flags, set DONE=1 and go to DONE.
REQ-014 MULT: SHALL perform 16 shift-add iterations on edges k+1..k+16 using a 4-bit counter (0..15); at edge k+17, SHALL write O and flags, set DONE=1 and go to DONE.
REQ-015 DONE state: SHALL last exactly one cycle; the next edge clears DONE and returns to IDLE.
REQ-016 START SHALL be ignored in EXEC, MULT and DONE; no queuing.
REQ-017 Arithmetic: ADD/SUB SHALL be modulo 2^16; MUL SHALL return the low 16 bits of the unsigned 32-bit product.
REQ-018 Shifts: SHALL shift L by R[3:0]; R[15:4] SHALL be ignored.
REQ-019 ZF SHALL be (O==0); NF SHALL be O[15].
REQ-020 CF SHALL be: ADD carry-out; SUB borrow (L<R unsigned); SHL/SHR last bit shifted out (0 when amount=0); MUL 1 if product[31:16] != 0; AND/OR/XOR 0.
REQ-021 O and flags SHALL hold their value between DONE pulses, and SHALL be unaffected by operand changes after capture.
REQ-022 Operands SHALL be taken as presented; the controller guarantees LOUT/ROUT were asserted the cycle before START (no Z/X filtering).

Reset
REQ-023 res=0 SHALL immediately force: state IDLE, O=16'h0000, ZF=NF=CF=0, DONE=0, BUSY=0, counter=0, captured operands=0.
REQ-024 Reset asserted mid-EXEC or mid-MULT SHALL abandon the operation; no DONE pulse SHALL follow.
REQ-025 START SHALL be accepted on the first rising edge after res returns high.

Structure
REQ-026 Shared package alu_pkg SHALL hold: data width 16, opcode constants, FSM state encodings.
REQ-027 The iterative multiplier SHALL be a sub-module alu_mul_seq with load, step and done signals; all other operations SHALL be inline.

Verification
REQ-028 ADD L=0xFFFF R=0x0001 -> O=0x0000, CF=1, ZF=1, NF=0; DONE high for one cycle after edge k+1.
REQ-029 SUB L=0x0003 R=0x0005 -> O=0xFFFE, CF=1, NF=1, ZF=0.
REQ-030 MUL 0x0012*0x0034 -> O=0x03A8, CF=0 at edge k+17; MUL 0x0100*0x0100 -> O=0x0000, CF=1, ZF=1.
REQ-031 START with OP=ADD pulsed at edge k+5 of a MUL -> ignored; BUSY stays 1; MUL result unchanged; only one DONE pulse.
REQ-032 res=0 at edge k+8 of a MUL -> O=0, DONE=0, BUSY=0 at once, no later DONE; new ADD after release completes normally.
REQ-033 SHL L=0x8001 R=0x0001 -> O=0x0002, CF=1; SHL R=0x0010 -> O=L, CF=0 (amount 0).
